// File: rtl/ahb_param_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_param_arbiter_if
// Bundles the request and grant signals between the AHB masters and the
// arbiter.
//   master modport : drives hbusreq/hlock/htrans/hready, observes the grants
//   slave modport  : the arbiter side, samples requests and drives the grants
//
// Request/grant semantics: hbusreq[i] and hlock[i] are levels held by master
// i for as long as it wants the bus (or a locked sequence). They are not
// pulses and carry no ready back-pressure. hgrant can only change on a rising
// hclk edge where hready=1 and htrans is IDLE or NONSEQ, which is the
// arbitration point. hmaster and hmastlock describe the address phase. They
// advance only on edges with hready=1, so they trail hgrant by one
// hready-qualified cycle.
// ---------------------------------------------------------------------------
interface ahb_param_arbiter_if #(
  parameter int NUM_MASTERS = 16,
  parameter int MW          = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
);
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [MW-1:0]          hmaster;
  logic                   hmastlock;

  modport master (
    output hbusreq, hlock, htrans, hready,
    input  hgrant, hmaster, hmastlock
  );

  modport slave (
    input  hbusreq, hlock, htrans, hready,
    output hgrant, hmaster, hmastlock
  );
endinterface

// File: rtl/ahb_param_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_param_arbiter
// Parametrised AHB bus arbiter. It supports fixed-priority or round-robin
// selection, a parked default master, locked transfers and an optional limit
// on how long an unlocked owner can hold the bus while others wait.
//
// Ports:
//   hclk        : bus clock, all state changes on the rising edge
//   hreset      : synchronous, active-high reset
//   bus         : request/grant bundle (slave modport), see the interface
//   dbg_state_o : FSM state (0 PARK, 1 OWN, 2 LOCK)
//   dbg_ptr_o   : round-robin search start pointer
//   dbg_hold_o  : hold counter of the current unlocked owner
//
// Parameters:
//   NUM_MASTERS    2..32
//   ARB_MODE       0 fixed priority (lowest index wins), 1 round-robin
//   DEFAULT_MASTER parked master, < NUM_MASTERS
//   MAX_HOLD       0 disables the limit, otherwise 1..255 cycles
// ---------------------------------------------------------------------------
module ahb_param_arbiter #(
  parameter  int NUM_MASTERS    = 16,
  parameter  int ARB_MODE       = 1,
  parameter  int DEFAULT_MASTER = 0,
  parameter  int MAX_HOLD       = 0,
  localparam int MW             = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                 hclk,
  input  logic                 hreset,
  ahb_param_arbiter_if.slave   bus,
  output logic [1:0]           dbg_state_o,
  output logic [MW-1:0]        dbg_ptr_o,
  output logic [7:0]           dbg_hold_o
);

  typedef enum logic [1:0] {
    ST_PARK = 2'd0,
    ST_OWN  = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  localparam logic [NUM_MASTERS-1:0] ONE_C     = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]          DEF_IDX_C = MW'(DEFAULT_MASTER);
  localparam logic [MW-1:0]          LAST_C    = MW'(NUM_MASTERS - 1);
  localparam logic [7:0]             MAXH_C    = 8'(MAX_HOLD);
  localparam bit                     HOLD_EN_C = (MAX_HOLD > 0);

  // Lowest set index of req. Callers only use it with at least one bit set.
  function automatic logic [MW-1:0] pick_low(input logic [NUM_MASTERS-1:0] req);
    logic [MW-1:0] idx;
    idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) idx = MW'(i);
    end
    return idx;
  endfunction

  // Round-robin pick. Rotate req so that bit 0 is the pointer position, find
  // the first set bit, then map the offset back to an absolute index modulo
  // NUM_MASTERS. NUM_MASTERS need not be a power of two.
  function automatic logic [MW-1:0] pick_rr(input logic [NUM_MASTERS-1:0] req,
                                            input logic [MW-1:0]          ptr);
    logic [2*NUM_MASTERS-1:0] dbl;
    logic [NUM_MASTERS-1:0]   rot;
    logic [MW-1:0]            off;
    int                       sum;
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_MASTERS-1:0];
    off = pick_low(rot);
    sum = int'(ptr) + int'(off);
    if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
    return MW'(sum);
  endfunction

  state_e                 state_q, state_d;
  logic [MW-1:0]          owner_q, owner_d;
  logic [MW-1:0]          ptr_q, ptr_d;
  logic [7:0]             hold_q, hold_d;
  logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
  logic [MW-1:0]          hmaster_q, hmaster_d;
  logic                   hmastlock_q, hmastlock_d;

  logic                   ap;
  logic                   owner_req, owner_lock, other_req, any_req;
  logic                   timeout;
  logic [NUM_MASTERS-1:0] cand;
  logic [MW-1:0]          winner;
  logic                   rearb, go_park, enter_lock;

  // Request decode. hgrant_q is the owner one-hot (DEFAULT_MASTER in PARK),
  // so hlock from any other master is masked out here.
  always_comb begin
    ap         = bus.hready && (bus.htrans == 2'b00 || bus.htrans == 2'b10);
    any_req    = |bus.hbusreq;
    owner_req  = |(bus.hbusreq & hgrant_q);
    owner_lock = |(bus.hlock & hgrant_q);
    other_req  = |(bus.hbusreq & ~hgrant_q);
    timeout    = HOLD_EN_C && (state_q == ST_OWN) && (hold_q >= MAXH_C) && other_req;
    // A timed-out owner is still requesting. Remove it from the candidates so
    // that the grant actually moves, in either arbitration mode.
    cand       = (timeout && owner_req) ? (bus.hbusreq & ~hgrant_q) : bus.hbusreq;
    winner     = (ARB_MODE == 0) ? pick_low(cand) : pick_rr(cand, ptr_q);
  end

  // Next-state logic. Nothing moves except at an arbitration point.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    rearb      = 1'b0;
    go_park    = 1'b0;
    enter_lock = 1'b0;

    if (ap) begin
      case (state_q)
        ST_PARK: begin
          if (any_req) rearb = 1'b1;
        end
        ST_OWN, ST_LOCK: begin
          if (state_q == ST_LOCK && owner_lock) begin
            state_d = ST_LOCK;
          end else begin
            // Leaving LOCK uses exactly the same rules as OWN.
            state_d = ST_OWN;
            if (owner_lock && owner_req) begin
              state_d    = ST_LOCK;
              enter_lock = 1'b1;
            end else if (!owner_req) begin
              if (any_req) rearb = 1'b1;
              else         go_park = 1'b1;
            end else if (timeout) begin
              rearb = 1'b1;
            end
          end
        end
        default: go_park = 1'b1;
      endcase
    end

    if (rearb) begin
      state_d = ST_OWN;
      owner_d = winner;
      ptr_d   = (winner == LAST_C) ? '0 : winner + 1'b1;
    end else if (go_park) begin
      state_d = ST_PARK;
      owner_d = DEF_IDX_C;
    end

    // The hold counter runs every cycle in OWN, including hready wait
    // states, while someone else waits. It restarts on any ownership change.
    if (state_q == ST_OWN && other_req && !rearb && !go_park && !enter_lock) begin
      hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
    end else begin
      hold_d = 8'd0;
    end
  end

  // Output logic. hmaster and hmastlock describe the address phase and only
  // advance on hready edges, so they trail the grant.
  always_comb begin
    hgrant_d    = ONE_C << owner_d;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    if (bus.hready) begin
      hmaster_d   = owner_q;
      hmastlock_d = (state_q == ST_LOCK) || enter_lock;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_PARK;
      owner_q     <= DEF_IDX_C;
      ptr_q       <= '0;
      hold_q      <= 8'd0;
      hgrant_q    <= ONE_C << DEF_IDX_C;
      hmaster_q   <= DEF_IDX_C;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;

  assign dbg_state_o   = state_q;
  assign dbg_ptr_o     = ptr_q;
  assign dbg_hold_o    = hold_q;

endmodule
